// File: rtl/cordic_pipe_param.sv
// cordic_pipe_param: fully pipelined CORDIC engine.
// Every sample carries its own mode: rotation or vectoring.
// A quadrant pre-rotation stage brings any angle into the convergence range.
// Micro-rotation stages follow, then an output stage that rounds off the guard bits.
// The whole pipeline advances only when the output register is empty or being consumed.

module cordic_pipe_param #(
    parameter int WIDTH       = 16,
    parameter int ANGLE_WIDTH = 32,
    parameter int ITER        = 16,
    parameter int GUARD       = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          mode,
    input  logic signed [WIDTH-1:0]       x_in,
    input  logic signed [WIDTH-1:0]       y_in,
    input  logic        [ANGLE_WIDTH-1:0] z_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_mode,
    output logic signed [WIDTH+1:0]       x_out,
    output logic signed [WIDTH+1:0]       y_out,
    output logic        [ANGLE_WIDTH-1:0] z_out
);

    localparam int DW = WIDTH + 2 + GUARD;
    localparam int AW = ANGLE_WIDTH;
    localparam logic        [AW-1:0] QUARTER = AW'(64'd1 << (AW - 2));
    localparam logic signed [DW-1:0] HALF    = DW'((64'd1 << GUARD) >> 1);

    // atan(2^-i) as a 32-bit binary angle, where a full circle is 2^32
    function automatic logic [31:0] atan32(input int i);
        case (i)
            0:  return 32'h2000_0000;
            1:  return 32'h12E4_051E;
            2:  return 32'h09FB_385B;
            3:  return 32'h0511_11D4;
            4:  return 32'h028B_0D43;
            5:  return 32'h0145_D7E1;
            6:  return 32'h00A2_F61E;
            7:  return 32'h0051_7C55;
            8:  return 32'h0028_BE53;
            9:  return 32'h0014_5F2F;
            10: return 32'h000A_2F98;
            11: return 32'h0005_17CC;
            12: return 32'h0002_8BE6;
            13: return 32'h0001_45F3;
            14: return 32'h0000_A2FA;
            15: return 32'h0000_517D;
            16: return 32'h0000_28BE;
            17: return 32'h0000_145F;
            18: return 32'h0000_0A30;
            19: return 32'h0000_0518;
            20: return 32'h0000_028C;
            21: return 32'h0000_0146;
            22: return 32'h0000_00A3;
            23: return 32'h0000_0051;
            24: return 32'h0000_0029;
            25: return 32'h0000_0014;
            26: return 32'h0000_000A;
            27: return 32'h0000_0005;
            28: return 32'h0000_0003;
            29: return 32'h0000_0001;
            30: return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // the 32-bit table entry rescaled to ANGLE_WIDTH, rounded to nearest
    function automatic logic [AW-1:0] atanScaled(input int i);
        logic [63:0] t;
        int          sh;
        t  = {32'd0, atan32(i)};
        sh = 32 - AW;
        if (sh > 0) begin
            t = (t + (64'd1 << (sh - 1))) >> sh;
        end
        return AW'(t);
    endfunction

    logic signed [DW-1:0] r_x [0:ITER];
    logic signed [DW-1:0] r_y [0:ITER];
    logic        [AW-1:0] r_z [0:ITER];
    logic        [ITER:0] r_v;
    logic        [ITER:0] r_m;

    logic signed [WIDTH+1:0] r_xOut;
    logic signed [WIDTH+1:0] r_yOut;
    logic        [AW-1:0]    r_zOut;
    logic                    r_vOut;
    logic                    r_mOut;

    logic                    w_adv;
    logic signed [DW-1:0]    w_xExt;
    logic signed [DW-1:0]    w_yExt;
    logic signed [DW-1:0]    w_x0;
    logic signed [DW-1:0]    w_y0;
    logic        [AW-1:0]    w_z0;
    logic signed [DW-1:0]    w_xNext [0:ITER-1];
    logic signed [DW-1:0]    w_yNext [0:ITER-1];
    logic        [AW-1:0]    w_zNext [0:ITER-1];
    logic signed [WIDTH+1:0] w_xRnd;
    logic signed [WIDTH+1:0] w_yRnd;

    assign w_adv     = out_ready | ~r_vOut;
    assign in_ready  = w_adv;
    assign out_valid = r_vOut;
    assign out_mode  = r_mOut;
    assign x_out     = r_xOut;
    assign y_out     = r_yOut;
    assign z_out     = r_zOut;

    assign w_xExt = DW'(x_in) <<< GUARD;
    assign w_yExt = DW'(y_in) <<< GUARD;

    assign w_xRnd = (WIDTH + 2)'((r_x[ITER] + HALF) >>> GUARD);
    assign w_yRnd = (WIDTH + 2)'((r_y[ITER] + HALF) >>> GUARD);

    // quadrant pre-rotation: fold the input into the +/-90 degree convergence range
    always_comb begin
        w_x0 = w_xExt;
        w_y0 = w_yExt;
        w_z0 = z_in;
        if (!mode) begin
            case (z_in[AW-1:AW-2])
                2'b01: begin
                    w_x0 = -w_yExt;
                    w_y0 = w_xExt;
                    w_z0 = z_in - QUARTER;
                end
                2'b10: begin
                    w_x0 = w_yExt;
                    w_y0 = -w_xExt;
                    w_z0 = z_in + QUARTER;
                end
                default: ;
            endcase
        end else begin
            w_z0 = '0;
            if (w_xExt[DW-1]) begin
                if (!w_yExt[DW-1]) begin
                    w_x0 = w_yExt;
                    w_y0 = -w_xExt;
                    w_z0 = QUARTER;
                end else begin
                    w_x0 = -w_yExt;
                    w_y0 = w_xExt;
                    w_z0 = -QUARTER;
                end
            end
        end
    end

    // micro-rotations: rotation steers by the sign of z, vectoring drives y toward zero
    always_comb begin
        for (int k = 0; k < ITER; k++) begin
            w_xNext[k] = r_x[k];
            w_yNext[k] = r_y[k];
            w_zNext[k] = r_z[k];
            if (r_m[k] ? r_y[k][DW-1] : ~r_z[k][AW-1]) begin
                w_xNext[k] = r_x[k] - (r_y[k] >>> k);
                w_yNext[k] = r_y[k] + (r_x[k] >>> k);
                w_zNext[k] = r_z[k] - atanScaled(k);
            end else begin
                w_xNext[k] = r_x[k] + (r_y[k] >>> k);
                w_yNext[k] = r_y[k] - (r_x[k] >>> k);
                w_zNext[k] = r_z[k] + atanScaled(k);
            end
        end
    end

    // pipeline registers: reset clears everything, a stall freezes every stage together
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v    <= '0;
            r_m    <= '0;
            r_vOut <= 1'b0;
            r_mOut <= 1'b0;
            r_xOut <= '0;
            r_yOut <= '0;
            r_zOut <= '0;
            for (int k = 0; k <= ITER; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
                r_z[k] <= '0;
            end
        end else if (w_adv) begin
            r_v[0] <= in_valid;
            r_m[0] <= mode;
            r_x[0] <= w_x0;
            r_y[0] <= w_y0;
            r_z[0] <= w_z0;
            for (int k = 0; k < ITER; k++) begin
                r_v[k+1] <= r_v[k];
                r_m[k+1] <= r_m[k];
                r_x[k+1] <= w_xNext[k];
                r_y[k+1] <= w_yNext[k];
                r_z[k+1] <= w_zNext[k];
            end
            r_vOut <= r_v[ITER];
            r_mOut <= r_m[ITER];
            r_xOut <= w_xRnd;
            r_yOut <= w_yRnd;
            r_zOut <= r_z[ITER];
        end
    end

endmodule
